// File: rtl/fpu_req_pkg.sv
// Shared types and default widths for the FPU request sequencer.
package fpu_req_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DIM_W    = 17;
  localparam int unsigned STRIDE_W = 19;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } req_state_t;

  // Frame job configuration captured at start.
  typedef struct packed {
    logic                read;
    logic                write;
    logic [DIM_W-1:0]    width;
    logic [DIM_W-1:0]    height;
    logic [ADDR_W-1:0]   rd_base;
    logic [ADDR_W-1:0]   wr_base;
    logic [STRIDE_W-1:0] in_stride;
    logic [STRIDE_W-1:0] out_stride;
  } fpu_job_t;

endpackage

// File: rtl/fpu_row_addr_gen.sv
// Base-plus-stride row address accumulator; wraps modulo 2^ADDR_W.
module fpu_row_addr_gen #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned STRIDE_W = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [ADDR_W-1:0]   base_i,
  input  logic                step_i,
  input  logic [STRIDE_W-1:0] stride_i,
  output logic [ADDR_W-1:0]   addr_o
);

  logic [ADDR_W-1:0] acc_q, acc_d;

  // Load the frame base, or advance by one zero-extended row stride.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = base_i;
    end else if (step_i) begin
      acc_d = acc_q + {{(ADDR_W-STRIDE_W){1'b0}}, stride_i};
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign addr_o = acc_q;

endmodule

// File: rtl/fpu_request_sequencer.sv
// Walks a frame row by row issuing read/write burst requests; writes are
// gated by row-completion credits from the FPU datapath.
module fpu_request_sequencer
  import fpu_req_pkg::*;
#(
  parameter int unsigned ADDR_W   = fpu_req_pkg::ADDR_W,
  parameter int unsigned DIM_W    = fpu_req_pkg::DIM_W,
  parameter int unsigned STRIDE_W = fpu_req_pkg::STRIDE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                read,
  input  logic                write,
  input  logic [DIM_W-1:0]    width,
  input  logic [DIM_W-1:0]    height,
  input  logic [ADDR_W-1:0]   read_address,
  input  logic [ADDR_W-1:0]   write_address,
  input  logic [STRIDE_W-1:0] input_row_width,
  input  logic [STRIDE_W-1:0] output_row_width,
  output logic                making_request,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DIM_W-1:0]    mem_req_len,
  input  logic                mem_done,
  input  logic                fpu_row_done,
  output logic                job_done
);

  req_state_t        state_q, state_d;
  fpu_job_t          job_q, job_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  credit_q, credit_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DIM_W-1:0]  len_q, len_d;

  logic              start;
  logic              last_row;
  logic              rd_step, wr_step;
  logic              credit_inc, credit_dec;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  assign start      = (state_q == IDLE) && (read || write);
  assign last_row   = (row_q == (job_q.height - DIM_W'(1)));
  assign credit_inc = fpu_row_done && (state_q != IDLE);
  assign credit_dec = valid_q && mem_req_ready && we_q;

  fpu_row_addr_gen #(
    .ADDR_W  (ADDR_W),
    .STRIDE_W(STRIDE_W)
  ) u_rd_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (start),
    .base_i  (read_address),
    .step_i  (rd_step),
    .stride_i(job_q.in_stride),
    .addr_o  (rd_addr)
  );

  fpu_row_addr_gen #(
    .ADDR_W  (ADDR_W),
    .STRIDE_W(STRIDE_W)
  ) u_wr_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (start),
    .base_i  (write_address),
    .step_i  (wr_step),
    .stride_i(job_q.out_stride),
    .addr_o  (wr_addr)
  );

  // Next-state, job latch, row counter and registered request fields.
  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    row_d   = row_q;
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rd_step = 1'b0;
    wr_step = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          job_d.read       = read;
          job_d.write      = write;
          job_d.width      = width;
          job_d.height     = height;
          job_d.rd_base    = read_address;
          job_d.wr_base    = write_address;
          job_d.in_stride  = input_row_width;
          job_d.out_stride = output_row_width;
          row_d            = '0;
          if ((width == '0) || (height == '0)) begin
            state_d = DONE;
          end else if (read) begin
            state_d = RD_REQ;
          end else begin
            state_d = WR_REQ;
          end
        end
      end

      RD_REQ: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          we_d    = 1'b0;
          addr_d  = rd_addr;
          len_d   = job_q.width;
        end else if (mem_req_ready) begin
          valid_d = 1'b0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (mem_done) begin
          rd_step = 1'b1;
          if (job_q.write) begin
            state_d = WR_REQ;
          end else if (last_row) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + DIM_W'(1);
            state_d = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        if (!valid_q) begin
          if (credit_q != '0) begin
            valid_d = 1'b1;
            we_d    = 1'b1;
            addr_d  = wr_addr;
            len_d   = job_q.width;
          end
        end else if (mem_req_ready) begin
          valid_d = 1'b0;
          state_d = WR_WAIT;
        end
      end

      WR_WAIT: begin
        if (mem_done) begin
          wr_step = 1'b1;
          if (last_row) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + DIM_W'(1);
            state_d = job_q.read ? RD_REQ : WR_REQ;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Row credits: saturating up on datapath row completion, down on write accept.
  always_comb begin
    credit_d = credit_q;
    if (start) begin
      credit_d = '0;
    end else if (credit_inc && !credit_dec) begin
      if (credit_q != '1) begin
        credit_d = credit_q + DIM_W'(1);
      end
    end else if (credit_dec && !credit_inc) begin
      credit_d = credit_q - DIM_W'(1);
    end
  end

  // State, job and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      job_q    <= '0;
      row_q    <= '0;
      credit_q <= '0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      row_q    <= row_d;
      credit_q <= credit_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
    end
  end

  assign making_request = (state_q != IDLE);
  assign job_done       = (state_q == DONE);
  assign mem_req_valid  = valid_q;
  assign mem_req_we     = we_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_len    = len_q;

endmodule

// File: tb/tb_fpu_request_sequencer.sv
// Directed bench for fpu_request_sequencer.
module tb_fpu_request_sequencer;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 17;
  localparam int unsigned SW = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] width = '0;
  logic [DW-1:0] height = '0;
  logic [AW-1:0] read_address = '0;
  logic [AW-1:0] write_address = '0;
  logic [SW-1:0] input_row_width = '0;
  logic [SW-1:0] output_row_width = '0;
  logic          making_request;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic          mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_len;
  logic          mem_done = 1'b0;
  logic          fpu_row_done = 1'b0;
  logic          job_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] len;
    logic          credit;
  } req_t;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [DW-1:0] w;
    logic [DW-1:0] h;
  } zjob_t;

  req_t  rw_tab[6];
  req_t  wrap_tab[2];
  zjob_t zero_tab[4];

  fpu_request_sequencer #(
    .ADDR_W  (AW),
    .DIM_W   (DW),
    .STRIDE_W(SW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .read            (read),
    .write           (write),
    .width           (width),
    .height          (height),
    .read_address    (read_address),
    .write_address   (write_address),
    .input_row_width (input_row_width),
    .output_row_width(output_row_width),
    .making_request  (making_request),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_len     (mem_req_len),
    .mem_done        (mem_done),
    .fpu_row_done    (fpu_row_done),
    .job_done        (job_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a job for one edge, then scramble config to show it is ignored.
  task automatic start_job(input logic rd, input logic wr, input logic [DW-1:0] w,
                           input logic [DW-1:0] h, input logic [AW-1:0] ra,
                           input logic [AW-1:0] wa, input logic [SW-1:0] is,
                           input logic [SW-1:0] os);
    read = rd; write = wr; width = w; height = h;
    read_address = ra; write_address = wa;
    input_row_width = is; output_row_width = os;
    tick;
    read = 1'b0; write = 1'b0; width = 17'h1abcd; height = 17'h0f0f0;
    read_address = 32'hdead_beef; write_address = 32'hcafe_f00d;
    input_row_width = 19'h7_1234; output_row_width = 19'h5_4321;
  endtask

  // Optionally grant one credit, wait for a request, check it, accept, complete.
  task automatic do_request(input req_t r, input string tag);
    bit seen;
    seen = 1'b0;
    if (r.credit) begin
      fpu_row_done = 1'b1;
      tick;
      fpu_row_done = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_we"}, 64'(mem_req_we), 64'(r.we));
    chk({tag, "_addr"}, 64'(mem_req_addr), 64'(r.addr));
    chk({tag, "_len"}, 64'(mem_req_len), 64'(r.len));
    tick;
    chk({tag, "_drop"}, 64'(mem_req_valid), 64'd0);
    mem_done = 1'b1;
    tick;
    mem_done = 1'b0;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_jd"}, 64'(job_done), 64'd1);
    chk({tag, "_mr"}, 64'(making_request), 64'd1);
    tick;
    chk({tag, "_jd_fall"}, 64'(job_done), 64'd0);
    chk({tag, "_mr_fall"}, 64'(making_request), 64'd0);
    chk({tag, "_v_idle"}, 64'(mem_req_valid), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_len;
    int            vcount;

    rw_tab[0] = '{we: 1'b0, addr: 32'h0000_1000, len: 17'd64, credit: 1'b0};
    rw_tab[1] = '{we: 1'b1, addr: 32'h0000_8000, len: 17'd64, credit: 1'b1};
    rw_tab[2] = '{we: 1'b0, addr: 32'h0000_1100, len: 17'd64, credit: 1'b0};
    rw_tab[3] = '{we: 1'b1, addr: 32'h0000_8080, len: 17'd64, credit: 1'b1};
    rw_tab[4] = '{we: 1'b0, addr: 32'h0000_1200, len: 17'd64, credit: 1'b0};
    rw_tab[5] = '{we: 1'b1, addr: 32'h0000_8100, len: 17'd64, credit: 1'b1};
    wrap_tab[0] = '{we: 1'b0, addr: 32'hffff_ff80, len: 17'd16, credit: 1'b0};
    wrap_tab[1] = '{we: 1'b0, addr: 32'h0000_0080, len: 17'd16, credit: 1'b0};
    zero_tab[0] = '{rd: 1'b1, wr: 1'b0, w: 17'd64, h: 17'd0};
    zero_tab[1] = '{rd: 1'b1, wr: 1'b0, w: 17'd0,  h: 17'd3};
    zero_tab[2] = '{rd: 1'b0, wr: 1'b1, w: 17'd0,  h: 17'd0};
    zero_tab[3] = '{rd: 1'b1, wr: 1'b1, w: 17'd64, h: 17'd0};

    // Reset
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    chk("rst_mr", 64'(making_request), 64'd0);
    chk("rst_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_jd", 64'(job_done), 64'd0);
    chk("rst_addr", 64'(mem_req_addr), 64'd0);

    // Read+write frame, 3 rows
    start_job(1'b1, 1'b1, 17'd64, 17'd3, 32'h1000, 32'h8000, 19'd256, 19'd128);
    chk("rw_mr_start", 64'(making_request), 64'd1);
    chk("rw_v_latency", 64'(mem_req_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      do_request(rw_tab[i], $sformatf("rw%0d", i));
    end
    check_done("rw");

    // Write-only: no credit means no write request
    start_job(1'b0, 1'b1, 17'd32, 17'd2, 32'h0, 32'h8000, 19'd0, 19'd128);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid) vcount++;
      tick;
    end
    chk("wo_gated", 64'(vcount), 64'd0);
    do_request('{we: 1'b1, addr: 32'h8000, len: 17'd32, credit: 1'b1}, "wo0");
    do_request('{we: 1'b1, addr: 32'h8080, len: 17'd32, credit: 1'b1}, "wo1");
    check_done("wo");

    // Back-pressure, plus mem_done coincident with the handshake is ignored
    mem_req_ready = 1'b0;
    start_job(1'b1, 1'b0, 17'd48, 17'd1, 32'h0000_2000, 32'h0, 19'd64, 19'd0);
    tick;
    chk("bp_valid", 64'(mem_req_valid), 64'd1);
    chk("bp_addr0", 64'(mem_req_addr), 64'h2000);
    hold_addr = mem_req_addr;
    hold_len  = mem_req_len;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("bp_hold_v%0d", i), 64'(mem_req_valid), 64'd1);
      chk($sformatf("bp_hold_a%0d", i), 64'(mem_req_addr), 64'(hold_addr));
      chk($sformatf("bp_hold_l%0d", i), 64'(mem_req_len), 64'(hold_len));
      chk($sformatf("bp_hold_w%0d", i), 64'(mem_req_we), 64'd0);
    end
    mem_req_ready = 1'b1;
    mem_done = 1'b1;
    tick;
    mem_done = 1'b0;
    chk("bp_accept_drop", 64'(mem_req_valid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk($sformatf("bp_nodup%0d", i), 64'(mem_req_valid), 64'd0);
      chk($sformatf("bp_early_done%0d", i), 64'(job_done), 64'd0);
      chk($sformatf("bp_busy%0d", i), 64'(making_request), 64'd1);
    end
    mem_done = 1'b1;
    tick;
    mem_done = 1'b0;
    check_done("bp");

    // Zero-size jobs
    for (int i = 0; i < 4; i++) begin
      start_job(zero_tab[i].rd, zero_tab[i].wr, zero_tab[i].w, zero_tab[i].h,
                32'h3000, 32'h4000, 19'd16, 19'd16);
      chk($sformatf("zero%0d_v", i), 64'(mem_req_valid), 64'd0);
      check_done($sformatf("zero%0d", i));
    end

    // Address wrap
    start_job(1'b1, 1'b0, 17'd16, 17'd2, 32'hffff_ff80, 32'h0, 19'd256, 19'd0);
    for (int i = 0; i < 2; i++) begin
      do_request(wrap_tab[i], $sformatf("wrap%0d", i));
    end
    check_done("wrap");

    // Reset during WR_WAIT, stale mem_done afterwards
    start_job(1'b0, 1'b1, 17'd64, 17'd2, 32'h0, 32'h8000, 19'd0, 19'd128);
    fpu_row_done = 1'b1;
    tick;
    tick;
    fpu_row_done = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) break;
      vcount++;
      tick;
    end
    chk("rst_wr_seen", 64'(mem_req_valid), 64'd1);
    tick;
    rst_n = 1'b0;
    #2;
    chk("rstmid_mr", 64'(making_request), 64'd0);
    chk("rstmid_valid", 64'(mem_req_valid), 64'd0);
    chk("rstmid_we", 64'(mem_req_we), 64'd0);
    chk("rstmid_addr", 64'(mem_req_addr), 64'd0);
    tick;
    rst_n = 1'b1;
    mem_done = 1'b1;
    tick;
    mem_done = 1'b0;
    tick;
    chk("rstpost_mr", 64'(making_request), 64'd0);
    chk("rstpost_jd", 64'(job_done), 64'd0);
    chk("rstpost_valid", 64'(mem_req_valid), 64'd0);
    chk("rstpost_len", 64'(mem_req_len), 64'd0);
    start_job(1'b0, 1'b1, 17'd8, 17'd1, 32'h0, 32'h0000_9000, 19'd0, 19'd64);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req_valid) vcount++;
      tick;
    end
    chk("rstpost_nocredit", 64'(vcount), 64'd0);
    do_request('{we: 1'b1, addr: 32'h9000, len: 17'd8, credit: 1'b1}, "rstjob");
    check_done("rstjob");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
